// File: rtl/display_scan.sv
// display_scan: time-multiplexed digit scanner for a common-anode
// multi-digit seven-segment display.
//
// Once per frame the packed digit values and decimal-point requests are
// snapshotted. The scanner then steps through the digits one slot at a time.
// Each slot is REFRESH_DIV cycles: BLANK_CYCLES with every anode off to
// avoid ghosting, then the selected digit is shown with its anode driven low.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           scan enable; 0 keeps the display dark
//   digits_in    packed nibbles, nibble i = digit i (digit 0 is rightmost)
//   dp_in        per-digit decimal point request, active high
//   lz_blank_en  leading-zero suppression enable (static config, used live)
//   digit_data   selected digit value, to the hex-to-7seg decoder
//   anodes       digit enables, active low, at most one low at a time
//   dp_n         decimal point segment, active low
//   frame_start  one-cycle pulse whenever a new snapshot is taken

// Per-digit leading-zero stage: this digit and every digit above it are zero.
module display_scan_digit (
  input  logic [3:0] nib,
  input  logic       upper_zero,
  output logic       all_zero
);
  assign all_zero = upper_zero & (nib == 4'h0);
endmodule

module display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  output logic [3:0]              digit_data,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int CW          = $clog2(REFRESH_DIV);
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                       state, state_d;
  logic [IW-1:0]                idx, idx_d;
  logic [CW-1:0]                cnt, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]   snap, snap_d;
  logic [NUM_DIGITS-1:0]        snap_dp, snap_dp_d;
  logic                         fs_d;

  // Suppression chain runs from the top digit down; digit 0 never blanks.
  logic [NUM_DIGITS:1]          zchain;
  logic [NUM_DIGITS-1:0]        sup;
  logic                         cur_sup;

  assign zchain[NUM_DIGITS] = 1'b1;
  assign sup[0]             = 1'b0;

  genvar i;
  generate
    for (i = 1; i < NUM_DIGITS; i++) begin : g_dig
      display_scan_digit u_dig (
        .nib        (snap[i]),
        .upper_zero (zchain[i+1]),
        .all_zero   (zchain[i])
      );
      assign sup[i] = zchain[i];
    end
  endgenerate

  assign cur_sup = lz_blank_en & sup[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      snap        <= '0;
      snap_dp     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      snap        <= snap_d;
      snap_dp     <= snap_dp_d;
      frame_start <= fs_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    snap_d    = snap;
    snap_dp_d = snap_dp;
    fs_d      = 1'b0;
    // Dropping en wins over everything; the snapshot is kept.
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = '0;
          cnt_d     = '0;
          snap_d    = digits_in;
          snap_dp_d = dp_in;
          fs_d      = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx == IDX_LAST) begin
              // Frame boundary: fresh snapshot keeps the display tear-free.
              idx_d     = '0;
              snap_d    = digits_in;
              snap_dp_d = dp_in;
              fs_d      = 1'b1;
            end else begin
              idx_d = idx + 1'b1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from registered state only (plus the static lz config).
  always_comb begin
    digit_data = 4'h0;
    anodes     = '1;
    dp_n       = 1'b1;
    case (state)
      BLANK: digit_data = snap[idx];
      SHOW: begin
        digit_data = snap[idx];
        if (!cur_sup) begin
          anodes[idx] = 1'b0;
          dp_n        = ~snap_dp[idx];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           rst_n, en, lz;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp;
  logic [3:0]     digit_data;
  logic [N-1:0]   anodes;
  logic           dp_n, frame_start;

  int npass = 0, nfail = 0, ntot = 0;

  // Reference model: position in the scan is just elapsed cycles since the
  // scan started; slot and blank/show phase follow by division.
  bit             m_act = 0;
  int             m_t   = 0;
  logic [4*N-1:0] m_snap = '0;
  logic [N-1:0]   m_dp   = '0;
  bit             m_fs   = 0;

  display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digits_in   (digits),
    .dp_in       (dp),
    .lz_blank_en (lz),
    .digit_data  (digit_data),
    .anodes      (anodes),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot();
    return (m_t / R) % N;
  endfunction

  function automatic bit showing();
    return m_act && ((m_t % R) >= B);
  endfunction

  task automatic model_edge();
    if (!en) begin
      m_act = 0;
      m_fs  = 0;
    end else if (!m_act) begin
      m_act  = 1;
      m_t    = 0;
      m_snap = digits;
      m_dp   = dp;
      m_fs   = 1;
    end else begin
      m_t++;
      if (m_t % (N*R) == 0) begin
        m_snap = digits;
        m_dp   = dp;
        m_fs   = 1;
      end else begin
        m_fs = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] ea;
    logic [3:0]   ed;
    logic         edp;
    int           s;
    bit           sup;
    ea  = '1;
    ed  = 4'h0;
    edp = 1'b1;
    if (m_act) begin
      s  = slot();
      ed = m_snap[4*s +: 4];
      if (showing()) begin
        sup = lz && (s > 0) && ((m_snap >> (4*s)) == 0);
        if (!sup) begin
          ea[s] = 1'b0;
          edp   = ~m_dp[s];
        end
      end
    end
    chk({tag, ".anodes"}, anodes, ea);
    chk({tag, ".data"}, digit_data, ed);
    chk({tag, ".dp_n"}, dp_n, edp);
    chk({tag, ".fs"}, frame_start, m_fs);
    chk({tag, ".onehot"}, ($countones(~anodes) <= 1), 1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic seek_frame(input string tag);
    int k = 0;
    do begin
      tick(tag);
      k++;
    end while ((m_t % (N*R) != 0) && k < 100);
    chk({tag, ".seek"}, (k < 100), 1);
  endtask

  task automatic seek_show(input string tag, input int s);
    int k = 0;
    while (!(showing() && slot() == s) && k < 100) begin
      tick(tag);
      k++;
    end
    chk({tag, ".seek"}, (k < 100), 1);
  endtask

  initial begin
    int fs_cnt, dp_cnt;
    rst_n  = 1'b0;
    en     = 1'b0;
    lz     = 1'b0;
    digits = 16'h1234;
    dp     = '0;
    #3;
    chk("reset.anodes", anodes, 4'hF);
    chk("reset.data", digit_data, 4'h0);
    chk("reset.dp_n", dp_n, 1'b1);
    chk("reset.fs", frame_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Basic scan plus mid-frame change during digit-1 show
    fs_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      tick("scan");
      if (frame_start) fs_cnt++;
      if (k == 11) digits = 16'hABCD;
    end
    chk("scan.fs_pulses", fs_cnt, 2);

    // Leading-zero suppression
    lz     = 1'b1;
    digits = 16'h0050;
    seek_frame("lz50");
    for (int k = 0; k < 32; k++) tick("lz50");
    digits = 16'h0000;
    seek_frame("lz00");
    for (int k = 0; k < 32; k++) tick("lz00");

    // Decimal point on a suppressed digit stays dark
    dp = 4'b0100;
    seek_frame("dp_sup");
    dp_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      if (dp_n === 1'b0) dp_cnt++;
      tick("dp_sup");
    end
    chk("dp_sup.count", dp_cnt, 0);

    // Decimal point on a lit digit: exactly the 6 digit-2 show cycles
    lz     = 1'b0;
    digits = 16'h0050;
    seek_frame("dp");
    dp_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      if (dp_n === 1'b0) dp_cnt++;
      tick("dp");
    end
    chk("dp.count", dp_cnt, 6);

    // Enable drop during digit-2 show, then restart
    seek_show("drop", 2);
    en = 1'b0;
    tick("drop");
    chk("drop.anodes_F", anodes, 4'hF);
    chk("drop.data_0", digit_data, 4'h0);
    en = 1'b1;
    tick("reen");
    chk("reen.fs_1", frame_start, 1'b1);
    tick("reen_blank");
    chk("reen_blank.anodes_F", anodes, 4'hF);
    tick("reen_show");
    chk("reen_show.anodes", anodes, 4'b1110);

    // Randomized run
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 11) == 0) digits = 16'($urandom) >> (4*$urandom_range(0, 4));
      if ($urandom_range(0, 11) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 39) == 0) lz = ~lz;
      en = ($urandom_range(0, 49) != 0);
      tick("rand");
    end
    en = 1'b1;

    // Async reset mid-show, between clock edges
    seek_show("areset", 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.anodes", anodes, 4'hF);
    chk("areset.dp_n", dp_n, 1'b1);
    chk("areset.data", digit_data, 4'h0);
    m_act  = 0;
    m_snap = '0;
    m_dp   = '0;
    m_fs   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) tick("post_reset");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
